// File: rtl/pic_frame_seq_if.sv
// Bundle of SD/LCD operation handshakes, UART control request lines and the
// status outputs of the picture frame sequencer.
// master: the sequencer side; slave: the SD/LCD/UART/LED side.
interface pic_frame_seq_if #(
   parameter int IDX_W = 4,
   parameter int BLK_W = 9
);
   logic             SD_if_busy;
   logic             LCD_if_busy;
   logic             ctl_incr;
   logic             ctl_decr;
   logic             ctl_valid;
   logic [IDX_W-1:0] SD_if_im_idx;
   logic [BLK_W-1:0] SD_if_blk_off;
   logic             SD_if_init;
   logic             SD_if_send_rd_cmd;
   logic             SD_if_stream;
   logic             SD_if_end_of_frame;
   logic             SD_if_begin;
   logic             LCD_if_init;
   logic             LCD_if_send_px_cmd;
   logic             LCD_if_stream;
   logic             LCD_if_end_of_frame;
   logic             LCD_if_begin;
   logic             ctl_ready;
   logic             sys_wait_led;

   modport master (
      input  SD_if_busy, LCD_if_busy, ctl_incr, ctl_decr, ctl_valid,
      output SD_if_im_idx, SD_if_blk_off,
      output SD_if_init, SD_if_send_rd_cmd, SD_if_stream, SD_if_end_of_frame, SD_if_begin,
      output LCD_if_init, LCD_if_send_px_cmd, LCD_if_stream, LCD_if_end_of_frame, LCD_if_begin,
      output ctl_ready, sys_wait_led
   );

   modport slave (
      output SD_if_busy, LCD_if_busy, ctl_incr, ctl_decr, ctl_valid,
      input  SD_if_im_idx, SD_if_blk_off,
      input  SD_if_init, SD_if_send_rd_cmd, SD_if_stream, SD_if_end_of_frame, SD_if_begin,
      input  LCD_if_init, LCD_if_send_px_cmd, LCD_if_stream, LCD_if_end_of_frame, LCD_if_begin,
      input  ctl_ready, sys_wait_led
   );
endinterface

// File: rtl/pic_frame_seq.sv
// Picture frame sequencer: walks SD card and LCD through init, frame command,
// block streaming and block re-commands, then waits for a UART next/previous
// image request. Optional slideshow auto-advance is enabled by defining the
// macro PIC_FRAME_SEQ_SLIDESHOW_EN.
module pic_frame_seq #(
   parameter int IDX_W         = 4,
   parameter int NUM_IMG       = 16,
   parameter int BLK_PER_FRAME = 300,
   parameter int SLIDE_TICKS   = 40000000
) (
   input logic           clk_4M,
   input logic           rst,
   pic_frame_seq_if.master bus
);
   localparam int BLK_W = $clog2(BLK_PER_FRAME + 1);

   typedef enum logic [4:0] {
      S_INIT      = 5'b00001,
      S_FRAME_CMD = 5'b00010,
      S_STREAM    = 5'b00100,
      S_BLK_CMD   = 5'b01000,
      S_WAIT_CTL  = 5'b10000
   } state_t;

   // wrap-around index arithmetic over NUM_IMG images
   function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] v);
      return (v == IDX_W'(NUM_IMG - 1)) ? '0 : v + 1'b1;
   endfunction

   function automatic logic [IDX_W-1:0] idx_prev(input logic [IDX_W-1:0] v);
      return (v == '0) ? IDX_W'(NUM_IMG - 1) : v - 1'b1;
   endfunction

   logic             sd_busy_p0, lcd_busy_p0;
   logic             incr_p0, decr_p0, vld_p0;

   state_t           state_q, state_d;
   logic             wait_lo_q, wait_lo_d;   // 0: begin phase, 1: waiting for busy to fall
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [BLK_W-1:0] blk_q, blk_d;

   logic             tgt_sd, tgt_lcd;
   logic             op_init, op_cmd, op_stream, op_eof;
   logic             all_hi, all_lo, op_done;
   logic             last_blk;
   logic [BLK_W-1:0] blk_inc;
   logic             go, go_up, go_dn;

`ifdef PIC_FRAME_SEQ_SLIDESHOW_EN
   localparam int TIM_W = $clog2(SLIDE_TICKS + 1);
   logic [TIM_W-1:0] tmr_q;
   logic             tmr_hit;

   assign tmr_hit = (tmr_q == TIM_W'(SLIDE_TICKS - 1));

   // slideshow timer: runs only while waiting for a request, zero elsewhere
   always_ff @(posedge clk_4M or posedge rst) begin
      if (rst) begin
         tmr_q <= '0;
      end else if (state_q != S_WAIT_CTL) begin
         tmr_q <= '0;
      end else if (!tmr_hit) begin
         tmr_q <= tmr_q + 1'b1;
      end
   end
`else
   logic unused_slide_ticks;
   assign unused_slide_ticks = ^SLIDE_TICKS;
`endif

   // input sampling stage: every decision uses these registered copies
   always_ff @(posedge clk_4M or posedge rst) begin
      if (rst) begin
         sd_busy_p0  <= 1'b0;
         lcd_busy_p0 <= 1'b0;
         incr_p0     <= 1'b0;
         decr_p0     <= 1'b0;
         vld_p0      <= 1'b0;
      end else begin
         sd_busy_p0  <= bus.SD_if_busy;
         lcd_busy_p0 <= bus.LCD_if_busy;
         incr_p0     <= bus.ctl_incr;
         decr_p0     <= bus.ctl_decr;
         vld_p0      <= bus.ctl_valid;
      end
   end

   // sequencer state, handshake phase, image index and block offset
   always_ff @(posedge clk_4M or posedge rst) begin
      if (rst) begin
         state_q   <= S_INIT;
         wait_lo_q <= 1'b0;
         idx_q     <= '0;
         blk_q     <= '0;
      end else begin
         state_q   <= state_d;
         wait_lo_q <= wait_lo_d;
         idx_q     <= idx_d;
         blk_q     <= blk_d;
      end
   end

   assign last_blk = (blk_q == BLK_W'(BLK_PER_FRAME - 1));
   assign blk_inc  = blk_q + 1'b1;

   // next-state logic, operation targets and the busy handshake
   always_comb begin
      state_d   = state_q;
      wait_lo_d = wait_lo_q;
      idx_d     = idx_q;
      blk_d     = blk_q;
      tgt_sd    = 1'b0;
      tgt_lcd   = 1'b0;
      op_init   = 1'b0;
      op_cmd    = 1'b0;
      op_stream = 1'b0;
      op_eof    = 1'b0;
      go        = 1'b0;
      go_up     = 1'b0;
      go_dn     = 1'b0;

      case (state_q)
         S_INIT: begin
            tgt_sd  = 1'b1;
            tgt_lcd = 1'b1;
            op_init = 1'b1;
         end
         S_FRAME_CMD: begin
            tgt_sd  = 1'b1;
            tgt_lcd = 1'b1;
            op_cmd  = 1'b1;
         end
         S_STREAM: begin
            tgt_sd    = 1'b1;
            tgt_lcd   = 1'b1;
            op_stream = 1'b1;
            op_eof    = last_blk;
         end
         S_BLK_CMD: begin
            tgt_sd = 1'b1;
            op_cmd = 1'b1;
         end
         default: ;
      endcase

      all_hi  = (!tgt_sd || sd_busy_p0) && (!tgt_lcd || lcd_busy_p0);
      all_lo  = (!tgt_sd || !sd_busy_p0) && (!tgt_lcd || !lcd_busy_p0);
      op_done = (tgt_sd || tgt_lcd) && wait_lo_q && all_lo;

      if ((tgt_sd || tgt_lcd) && !wait_lo_q && all_hi) begin
         wait_lo_d = 1'b1;
      end

      if (op_done) begin
         wait_lo_d = 1'b0;
         case (state_q)
            S_INIT: begin
               state_d = S_FRAME_CMD;
               blk_d   = '0;
            end
            S_FRAME_CMD: state_d = S_STREAM;
            S_STREAM: begin
               blk_d   = blk_inc;
               state_d = (blk_inc < BLK_W'(BLK_PER_FRAME)) ? S_BLK_CMD : S_WAIT_CTL;
            end
            S_BLK_CMD: state_d = S_STREAM;
            default:   state_d = S_INIT;
         endcase
      end

      if (state_q == S_WAIT_CTL) begin
         go    = vld_p0;
         go_up = incr_p0 && !decr_p0;
         go_dn = decr_p0 && !incr_p0;
`ifdef PIC_FRAME_SEQ_SLIDESHOW_EN
         // a UART request in the same cycle takes precedence over the timer
         if (!vld_p0 && tmr_hit) begin
            go    = 1'b1;
            go_up = 1'b1;
            go_dn = 1'b0;
         end
`endif
         if (go) begin
            state_d   = S_FRAME_CMD;
            wait_lo_d = 1'b0;
            blk_d     = '0;
            if (go_up) begin
               idx_d = idx_next(idx_q);
            end else if (go_dn) begin
               idx_d = idx_prev(idx_q);
            end
         end
      end

      if (state_q != S_INIT && state_q != S_FRAME_CMD && state_q != S_STREAM &&
          state_q != S_BLK_CMD && state_q != S_WAIT_CTL) begin
         state_d   = S_INIT;
         wait_lo_d = 1'b0;
      end
   end

   // op bits and begin are visible only during the begin phase
   assign bus.SD_if_im_idx        = idx_q;
   assign bus.SD_if_blk_off       = blk_q;
   assign bus.SD_if_begin         = tgt_sd && !wait_lo_q;
   assign bus.SD_if_init          = tgt_sd && !wait_lo_q && op_init;
   assign bus.SD_if_send_rd_cmd   = tgt_sd && !wait_lo_q && op_cmd;
   assign bus.SD_if_stream        = tgt_sd && !wait_lo_q && op_stream;
   assign bus.SD_if_end_of_frame  = tgt_sd && !wait_lo_q && op_eof;
   assign bus.LCD_if_begin        = tgt_lcd && !wait_lo_q;
   assign bus.LCD_if_init         = tgt_lcd && !wait_lo_q && op_init;
   assign bus.LCD_if_send_px_cmd  = tgt_lcd && !wait_lo_q && op_cmd;
   assign bus.LCD_if_stream       = tgt_lcd && !wait_lo_q && op_stream;
   assign bus.LCD_if_end_of_frame = tgt_lcd && !wait_lo_q && op_eof;
   assign bus.ctl_ready           = (state_q == S_WAIT_CTL);
   assign bus.sys_wait_led        = (state_q == S_WAIT_CTL);
endmodule

// File: tb/tb_pic_frame_seq.sv
// Directed bench for pic_frame_seq with a 3-block frame and 16 images.
// Define PIC_FRAME_SEQ_SLIDESHOW_EN to also exercise slideshow auto-advance.
module tb_pic_frame_seq;
   logic       clk_4M = 1'b0;
   logic       rst;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [3:0] exp_idx;

   pic_frame_seq_if #(.IDX_W(4), .BLK_W(2)) bus ();

   pic_frame_seq #(
      .IDX_W(4), .NUM_IMG(16), .BLK_PER_FRAME(3), .SLIDE_TICKS(100)
   ) dut (
      .clk_4M (clk_4M),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_4M = ~clk_4M;

   wire [4:0] sd_ops  = {bus.SD_if_init, bus.SD_if_send_rd_cmd, bus.SD_if_stream,
                         bus.SD_if_end_of_frame, bus.SD_if_begin};
   wire [4:0] lcd_ops = {bus.LCD_if_init, bus.LCD_if_send_px_cmd, bus.LCD_if_stream,
                         bus.LCD_if_end_of_frame, bus.LCD_if_begin};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_4M);
   endtask

   // one handshaked operation: wait for begin, check bits, pulse busy
   task automatic run_op(input string tag, input bit sd_t, input bit lcd_t,
                         input logic [4:0] e_sd, input logic [4:0] e_lcd,
                         input logic [1:0] e_blk, input bit hold_lcd);
      int n;
      n = 0;
      while (!(sd_t ? bus.SD_if_begin : bus.LCD_if_begin) && n < 20) begin
         step(1);
         n++;
      end
      chk({tag, "_sd"}, sd_ops, e_sd);
      chk({tag, "_lcd"}, lcd_ops, e_lcd);
      chk({tag, "_blk"}, bus.SD_if_blk_off, e_blk);
      chk({tag, "_idx"}, bus.SD_if_im_idx, exp_idx);
      chk({tag, "_rdy"}, bus.ctl_ready, 0);
      if (sd_t) bus.SD_if_busy = 1'b1;
      if (lcd_t && !hold_lcd) bus.LCD_if_busy = 1'b1;
      if (hold_lcd) begin
         step(10);
         chk({tag, "_hold_sd"}, sd_ops, e_sd);
         chk({tag, "_hold_lcd"}, lcd_ops, e_lcd);
         bus.LCD_if_busy = 1'b1;
      end
      n = 0;
      while ((sd_t ? bus.SD_if_begin : bus.LCD_if_begin) && n < 20) begin
         step(1);
         n++;
      end
      chk({tag, "_drop"}, {sd_ops, lcd_ops}, 0);
      step(1);
      chk({tag, "_blk_stable"}, bus.SD_if_blk_off, e_blk);
      bus.SD_if_busy  = 1'b0;
      bus.LCD_if_busy = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.ctl_ready && n < 10) begin
         step(1);
         n++;
      end
      chk("wait_rdy", bus.ctl_ready, 1);
      chk("wait_led", bus.sys_wait_led, 1);
      chk("wait_ops", {sd_ops, lcd_ops}, 0);
   endtask

   task automatic run_frame(input bit hold);
      run_op("frm", 1'b1, 1'b1, 5'b01001, 5'b01001, 2'd0, hold);
      for (int b = 0; b < 3; b++) begin
         run_op("strm", 1'b1, 1'b1, (b == 2) ? 5'b00111 : 5'b00101,
                (b == 2) ? 5'b00111 : 5'b00101, 2'(b), 1'b0);
         if (b < 2) run_op("blk", 1'b1, 1'b0, 5'b01001, 5'b00000, 2'(b + 1), 1'b0);
      end
      wait_ready();
   endtask

   // one-cycle UART request, then the sequencer must be in FRAME_CMD
   task automatic req(input bit inc, input bit dec);
      bus.ctl_valid = 1'b1;
      bus.ctl_incr  = inc;
      bus.ctl_decr  = dec;
      step(1);
      bus.ctl_valid = 1'b0;
      bus.ctl_incr  = 1'b0;
      bus.ctl_decr  = 1'b0;
      step(1);
      chk("req_idx", bus.SD_if_im_idx, exp_idx);
      chk("req_blk", bus.SD_if_blk_off, 0);
      chk("req_rdy", bus.ctl_ready, 0);
      chk("req_sd", sd_ops, 5'b01001);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_sd"}, sd_ops, 5'b10001);
      chk({tag, "_lcd"}, lcd_ops, 5'b10001);
      chk({tag, "_idx"}, bus.SD_if_im_idx, 0);
      chk({tag, "_blk"}, bus.SD_if_blk_off, 0);
      chk({tag, "_rdy"}, {bus.ctl_ready, bus.sys_wait_led}, 0);
   endtask

   initial begin
      int k;
      logic [3:0] old;
      rst             = 1'b1;
      bus.SD_if_busy  = 1'b0;
      bus.LCD_if_busy = 1'b0;
      bus.ctl_valid   = 1'b0;
      bus.ctl_incr    = 1'b0;
      bus.ctl_decr    = 1'b0;
      exp_idx         = 4'd0;
      step(3);
      chk_reset("rst");
      rst = 1'b0;

      // power-up: init then first frame with LCD busy held back on the frame command
      run_op("init", 1'b1, 1'b1, 5'b10001, 5'b10001, 2'd0, 1'b0);
      run_frame(1'b1);

      // decrement wraps 0 -> 15; a request during the frame is ignored
      exp_idx = 4'd15;
      req(1'b0, 1'b1);
      bus.ctl_valid = 1'b1;
      bus.ctl_incr  = 1'b1;
      step(2);
      bus.ctl_valid = 1'b0;
      bus.ctl_incr  = 1'b0;
      run_frame(1'b0);

      // increment wraps 15 -> 0
      exp_idx = 4'd0;
      req(1'b1, 1'b0);
      run_frame(1'b0);

      // both directions: same image, full redraw
      req(1'b1, 1'b1);
      run_frame(1'b0);

      // reset in the middle of the last stream
      exp_idx = 4'd1;
      req(1'b1, 1'b0);
      run_op("frm", 1'b1, 1'b1, 5'b01001, 5'b01001, 2'd0, 1'b0);
      run_op("strm", 1'b1, 1'b1, 5'b00101, 5'b00101, 2'd0, 1'b0);
      run_op("blk", 1'b1, 1'b0, 5'b01001, 5'b00000, 2'd1, 1'b0);
      run_op("strm", 1'b1, 1'b1, 5'b00101, 5'b00101, 2'd1, 1'b0);
      run_op("blk", 1'b1, 1'b0, 5'b01001, 5'b00000, 2'd2, 1'b0);
      k = 0;
      while (!bus.SD_if_begin && k < 20) begin
         step(1);
         k++;
      end
      chk("mid_sd", sd_ops, 5'b00111);
      chk("mid_blk", bus.SD_if_blk_off, 2);
      bus.SD_if_busy  = 1'b1;
      bus.LCD_if_busy = 1'b1;
      step(1);
      #2 rst = 1'b1;
      #1 chk_reset("arst");
      bus.SD_if_busy  = 1'b0;
      bus.LCD_if_busy = 1'b0;
      step(2);
      chk_reset("arst_hold");
      rst     = 1'b0;
      exp_idx = 4'd0;
      run_op("init2", 1'b1, 1'b1, 5'b10001, 5'b10001, 2'd0, 1'b0);
      run_frame(1'b0);

`ifdef PIC_FRAME_SEQ_SLIDESHOW_EN
      // auto-advance 100 cycles after entering WAIT_CTL
      old = bus.SD_if_im_idx;
      k   = 0;
      while (bus.SD_if_im_idx === old && k < 200) begin
         step(1);
         k++;
      end
      chk("slide_ticks", k, 100);
      chk("slide_idx", bus.SD_if_im_idx, 4'(old + 1));
`else
      old = 4'd0;
      k   = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pic_frame_seq.md
PIC_FRAME_SEQ -- requirements
Module: pic_frame_seq

Interface
REQ-001 Parameter IDX_W, default 4: image index width.
REQ-002 Parameter NUM_IMG, default 16: image count, 2..2^IDX_W; index wraps modulo NUM_IMG.
REQ-003 Parameter BLK_PER_FRAME, default 300: SD blocks per frame, >=1; BLK_W = clog2(BLK_PER_FRAME+1).
REQ-004 Parameter SLIDE_TICKS, default 40000000: auto-advance interval in clk_4M cycles (slideshow build only).
REQ-005 clk_4M  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 SD_if_busy, LCD_if_busy  in  1 each  interface busy.
REQ-008 ctl_incr, ctl_decr, ctl_valid  in  1 each  UART control request.
REQ-009 SD_if_im_idx  out  IDX_W  current image index.
REQ-010 SD_if_blk_off  out  BLK_W  block offset within frame.
REQ-011 SD_if_init, SD_if_send_rd_cmd, SD_if_stream, SD_if_end_of_frame, SD_if_begin  out  1 each  SD op bits and strobe.
REQ-012 LCD_if_init, LCD_if_send_px_cmd, LCD_if_stream, LCD_if_end_of_frame, LCD_if_begin  out  1 each  LCD op bits and strobe.
REQ-013 ctl_ready  out  1  controller accepts a UART request.
REQ-014 sys_wait_led  out  1  high exactly while in WAIT_CTL.

Function
REQ-015 All inputs registered once before use; every decision uses registered copies (2-cycle min reaction).
REQ-016 Operation handshake: op bit(s) and begin held high until every targeted interface's registered busy is high, then begin and op bits drop together; op completes when all targeted registered busy are low with begin low.
REQ-017 States: INIT, FRAME_CMD, STREAM, BLK_CMD, WAIT_CTL; one-hot state register.
REQ-018 INIT: SD and LCD init ops targeted; on completion -> FRAME_CMD, SD_if_blk_off=0.
REQ-019 FRAME_CMD: SD_if_send_rd_cmd and LCD_if_send_px_cmd targeted together; completion -> STREAM.
REQ-020 STREAM: SD_if_stream and LCD_if_stream targeted; SD_if_end_of_frame and LCD_if_end_of_frame high for the whole op iff SD_if_blk_off==BLK_PER_FRAME-1.
REQ-021 STREAM completion: SD_if_blk_off increments; if new value <BLK_PER_FRAME -> BLK_CMD (SD only), else -> WAIT_CTL with ctl_ready=1 next cycle.
REQ-022 BLK_CMD: SD_if_send_rd_cmd only; completion -> STREAM.
REQ-023 WAIT_CTL: on ctl_ready & registered ctl_valid, ctl_ready drops next cycle, index updates, SD_if_blk_off=0, -> FRAME_CMD.
REQ-024 Index update: incr only -> +1, NUM_IMG-1 wraps to 0; decr only -> -1, 0 wraps to NUM_IMG-1; both or neither -> unchanged but frame redrawn.
REQ-025 ctl_valid outside WAIT_CTL ignored, not queued; ctl_ready low outside WAIT_CTL.
REQ-026 SD_if_im_idx and SD_if_blk_off stable for the whole of any SD op.
REQ-027 Busy already high at begin assertion satisfies handshake; busy never rising holds state indefinitely.

Reset
REQ-028 Reset asserted: state=INIT, SD_if_im_idx=0, SD_if_blk_off=0, SD_if_init=SD_if_begin=LCD_if_init=LCD_if_begin=1, every other output 0, slide timer 0, input sample regs 0.
REQ-029 Reset mid-operation aborts immediately with no completion; deassertion restarts from INIT.

Configuration
REQ-030 Macro PIC_FRAME_SEQ_SLIDESHOW_EN defined: timer counts in WAIT_CTL, clears on entry; at SLIDE_TICKS-1 with no request, acts as incr-only request (REQ-023/024); UART request in same cycle wins.
REQ-031 Undefined: no timer logic; WAIT_CTL left only via UART request.

Verification
REQ-032 Reset release, both busy pulse 1->0 per op, BLK_PER_FRAME=3 -> INIT, FRAME_CMD, STREAM, BLK_CMD, STREAM, BLK_CMD, STREAM; end_of_frame high only on third stream; then ctl_ready=1, sys_wait_led=1.
REQ-033 WAIT_CTL, idx=15, NUM_IMG=16, ctl_valid+ctl_incr -> idx=0, blk_off=0, FRAME_CMD; idx=0 with decr -> idx=15.
REQ-034 ctl_valid with incr and decr both set -> idx unchanged, full frame redrawn.
REQ-035 LCD_if_busy held low during FRAME_CMD -> begin and both cmd bits stay high, state frozen; busy pulse -> proceeds.
REQ-036 rst asserted mid-STREAM at blk_off=2 -> outputs at REQ-028 values same cycle; INIT resumes after release.
REQ-037 Slideshow build, SLIDE_TICKS=100, no ctl_valid -> idx increments 100 cycles after WAIT_CTL entry.
